// File: rtl/rc_ring_arb.sv
// rc_ring_arb: ring-slot scheduler for the RC ring controller.
// Transit traffic has priority; local F2C responses and C2F requests share free slots round-robin.
module rc_ring_arb #(
    parameter int MAX_OUT_RD = 4,
    parameter int STARVE_TH  = 16,
    parameter int CNT_W      = $clog2(STARVE_TH + 1),
    localparam int CRD_W     = $clog2(MAX_OUT_RD + 1)
) (
    input  logic             QClk,
    input  logic             RstQnnnH,
    input  logic             RingInputValid,
    input  logic             RingInputConsume,
    input  logic             F2cRspValid,
    input  logic             C2fReqValid,
    input  logic [1:0]       C2fReqOpcode,
    input  logic             RingRdRspRcvd,
    output logic             F2cRspGrant,
    output logic             C2fReqGrant,
    output logic [1:0]       RingWinnerQ101H,
    output logic [CRD_W-1:0] RdCreditsQ,
    output logic             StarveF2cQ,
    output logic             StarveC2fQ,
    output logic             CreditErrQ
);

    typedef enum logic [1:0] {
        BUBBLE_OUT   = 2'd0,
        RING_INPUT   = 2'd1,
        F2C_RESPONSE = 2'd2,
        C2F_REQUEST  = 2'd3
    } winner_t;

    typedef enum logic {
        LAST_F2C = 1'b0,
        LAST_C2F = 1'b1
    } last_t;

    localparam logic [1:0]       OP_RD   = 2'd0;
    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(MAX_OUT_RD);
    localparam logic [CNT_W-1:0] CNT_TH  = CNT_W'(STARVE_TH);

    winner_t          winner_d, winner_q;
    last_t            last_d, last_q;
    logic [CRD_W-1:0] crd_d, crd_q;
    logic             err_d, err_q;
    logic [CNT_W-1:0] f2c_cnt_d, f2c_cnt_q;
    logic [CNT_W-1:0] c2f_cnt_d, c2f_cnt_q;
    logic             f2c_starve_q, c2f_starve_q;
    logic             slot_free, f2c_elig, c2f_elig, rd_take;

    assign slot_free = !RingInputValid || RingInputConsume;
    assign f2c_elig  = F2cRspValid;
    assign c2f_elig  = C2fReqValid && ((C2fReqOpcode != OP_RD) || (crd_q != '0));

    always_comb begin
        F2cRspGrant = 1'b0;
        C2fReqGrant = 1'b0;
        winner_d    = BUBBLE_OUT;
        last_d      = last_q;
        if (!RstQnnnH) begin
            if (!slot_free) begin
                winner_d = RING_INPUT;
            end else if (f2c_elig && c2f_elig) begin
                if (last_q == LAST_C2F) F2cRspGrant = 1'b1;
                else                    C2fReqGrant = 1'b1;
            end else begin
                F2cRspGrant = f2c_elig;
                C2fReqGrant = c2f_elig;
            end
            if (F2cRspGrant) begin
                winner_d = F2C_RESPONSE;
                last_d   = LAST_F2C;
            end else if (C2fReqGrant) begin
                winner_d = C2F_REQUEST;
                last_d   = LAST_C2F;
            end
        end
    end

    assign rd_take = C2fReqGrant && (C2fReqOpcode == OP_RD);

    // A simultaneous take and return cancel out and never flag an error.
    always_comb begin
        crd_d = crd_q;
        err_d = err_q;
        case ({rd_take, RingRdRspRcvd})
            2'b10: crd_d = crd_q - CRD_W'(1);
            2'b01: begin
                if (crd_q == CRD_MAX) err_d = 1'b1;
                else                  crd_d = crd_q + CRD_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        f2c_cnt_d = f2c_cnt_q;
        c2f_cnt_d = c2f_cnt_q;
        if (!F2cRspValid || F2cRspGrant) f2c_cnt_d = '0;
        else if (f2c_cnt_q != CNT_TH)    f2c_cnt_d = f2c_cnt_q + CNT_W'(1);
        if (!C2fReqValid || C2fReqGrant) c2f_cnt_d = '0;
        else if (c2f_cnt_q != CNT_TH)    c2f_cnt_d = c2f_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            winner_q     <= BUBBLE_OUT;
            last_q       <= LAST_C2F;
            crd_q        <= CRD_MAX;
            err_q        <= 1'b0;
            f2c_cnt_q    <= '0;
            c2f_cnt_q    <= '0;
            f2c_starve_q <= 1'b0;
            c2f_starve_q <= 1'b0;
        end else begin
            winner_q     <= winner_d;
            last_q       <= last_d;
            crd_q        <= crd_d;
            err_q        <= err_d;
            f2c_cnt_q    <= f2c_cnt_d;
            c2f_cnt_q    <= c2f_cnt_d;
            f2c_starve_q <= (f2c_cnt_d == CNT_TH);
            c2f_starve_q <= (c2f_cnt_d == CNT_TH);
        end
    end

    assign RingWinnerQ101H = winner_q;
    assign RdCreditsQ      = crd_q;
    assign StarveF2cQ      = f2c_starve_q;
    assign StarveC2fQ      = c2f_starve_q;
    assign CreditErrQ      = err_q;

endmodule

// File: tb/tb_rc_ring_arb.sv
// Self-checking bench for rc_ring_arb: directed scenarios followed by random traffic,
// compared each cycle against a slot-level reference model.
module tb_rc_ring_arb;

    localparam int MAX_RD = 4;
    localparam int TH     = 4;
    localparam logic [1:0] OP_RD = 2'd0;
    localparam logic [1:0] OP_WR = 2'd1;

    logic       clk = 1'b0;
    logic       rst, riv, ric, fv, cv, rrsp;
    logic [1:0] cop;
    logic       fg, cg, sf, sc, ce;
    logic [1:0] win;
    logic [2:0] crd;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit m_known = 1'b0;
    int m_win, m_crd, m_wf, m_wc;
    bit m_err, f2c_turn;
    bit g_f, g_c;

    always #5 clk = ~clk;

    rc_ring_arb #(.MAX_OUT_RD(MAX_RD), .STARVE_TH(TH)) dut (
        .QClk(clk), .RstQnnnH(rst),
        .RingInputValid(riv), .RingInputConsume(ric),
        .F2cRspValid(fv), .C2fReqValid(cv), .C2fReqOpcode(cop),
        .RingRdRspRcvd(rrsp),
        .F2cRspGrant(fg), .C2fReqGrant(cg),
        .RingWinnerQ101H(win), .RdCreditsQ(crd),
        .StarveF2cQ(sf), .StarveC2fQ(sc), .CreditErrQ(ce)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit iv, input bit ic, input bit f, input bit c,
                         input logic [1:0] op, input bit rsp);
        rst = r; riv = iv; ric = ic; fv = f; cv = c; cop = op; rrsp = rsp;
    endtask

    // One clock cycle: check at the falling edge, then advance the model through the rising edge.
    task automatic step();
        bit free, f_ok, c_ok;
        int take;
        @(negedge clk);
        free = !riv || ric;
        f_ok = fv;
        c_ok = cv && (cop != OP_RD || m_crd > 0);
        g_f = 1'b0;
        g_c = 1'b0;
        if (!rst && free) begin
            if (f_ok && c_ok) begin
                g_f = f2c_turn;
                g_c = !f2c_turn;
            end else begin
                g_f = f_ok;
                g_c = c_ok;
            end
        end
        chk("f2c_grant", 8'(fg), 8'(g_f));
        chk("c2f_grant", 8'(cg), 8'(g_c));
        if (m_known) begin
            chk("winner",     8'(win), 8'(m_win));
            chk("rd_credits", 8'(crd), 8'(m_crd));
            chk("starve_f2c", 8'(sf),  8'(m_wf == TH));
            chk("starve_c2f", 8'(sc),  8'(m_wc == TH));
            chk("credit_err", 8'(ce),  8'(m_err));
        end
        if (rst) begin
            m_known  = 1'b1;
            m_win    = 0;
            m_crd    = MAX_RD;
            m_err    = 1'b0;
            m_wf     = 0;
            m_wc     = 0;
            f2c_turn = 1'b1;
        end else begin
            m_win = !free ? 1 : g_f ? 2 : g_c ? 3 : 0;
            if (g_f) f2c_turn = 1'b0;
            if (g_c) f2c_turn = 1'b1;
            take = (g_c && cop == OP_RD) ? 1 : 0;
            if (rrsp && take == 0 && m_crd == MAX_RD) m_err = 1'b1;
            else m_crd = m_crd - take + int'(rrsp);
            m_wf = (!fv || g_f) ? 0 : (m_wf < TH ? m_wf + 1 : TH);
            m_wc = (!cv || g_c) ? 0 : (m_wc < TH ? m_wc + 1 : TH);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        drive(1, 0, 0, 0, 0, OP_WR, 0);
        step();
        drive(0, 0, 0, 0, 0, OP_WR, 0);
        step();

        // ring busy with transit traffic: no grants, starvation after TH waits
        drive(0, 1, 0, 1, 1, OP_WR, 0);
        repeat (6) step();

        // ring idle, both local requesters pending: alternate F2C/C2F
        drive(0, 0, 0, 1, 1, OP_WR, 0);
        repeat (6) step();

        // exhaust RD credits
        drive(0, 0, 0, 0, 1, OP_RD, 0);
        repeat (4) step();
        drive(0, 0, 0, 1, 1, OP_RD, 0);
        step();
        step();
        drive(0, 0, 0, 0, 1, OP_RD, 1);
        step();
        drive(0, 0, 0, 0, 1, OP_RD, 0);
        step();
        drive(0, 0, 0, 0, 0, OP_RD, 0);
        step();

        // credits back to 2, then take and return together
        drive(0, 0, 0, 0, 0, OP_RD, 1);
        repeat (2) step();
        drive(0, 0, 0, 0, 1, OP_RD, 1);
        step();
        drive(0, 0, 0, 0, 0, OP_RD, 0);
        step();

        // returns up to and beyond the maximum: error is sticky
        drive(0, 0, 0, 0, 0, OP_RD, 1);
        repeat (3) step();
        drive(0, 0, 0, 0, 0, OP_RD, 0);
        repeat (2) step();

        // consumed ring message frees the slot for C2F
        drive(0, 1, 1, 0, 1, OP_WR, 0);
        step();
        drive(0, 1, 0, 0, 0, OP_WR, 0);
        step();

        // RD burst interrupted by reset
        drive(0, 0, 0, 0, 1, OP_RD, 0);
        repeat (2) step();
        drive(1, 0, 0, 0, 1, OP_RD, 0);
        step();
        drive(0, 0, 0, 0, 0, OP_WR, 0);
        step();

        // random traffic; local requesters hold valid and payload until granted
        fv = 1'b0;
        cv = 1'b0;
        for (int i = 0; i < 500; i++) begin
            rst  = ($urandom_range(63) == 0);
            riv  = ($urandom_range(1) == 1);
            ric  = riv && ($urandom_range(2) == 0);
            rrsp = ($urandom_range(3) == 0);
            if (!fv) fv = ($urandom_range(1) == 1);
            if (!cv) begin
                cv  = ($urandom_range(1) == 1);
                cop = ($urandom_range(1) == 1) ? OP_RD : 2'($urandom_range(3, 1));
            end
            step();
            if (g_f || rst) fv = 1'b0;
            if (g_c || rst) cv = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
